imem_fetch_port: RTL and testbench

Parametrised, BRAM-backed instruction memory with a valid/ready request/response interface, replacing the fixed-latency always-read instruction ROM. Sits between the fetch stage and on-chip instruction storage. Adds configurable depth, base address and read latency, backpressure buffering, fetch-error reporting, pipeline flush, and a runtime load (write) port for boot-time image programming.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_rsp_fifo.sv | 62 ++++++
 rtl/imem_fetch_port.sv | 154 +++++++++++++++
 tb/tb_imem_fetch_port.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction fetch port
package imem_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } fetch_err_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        fetch_err_e  err;
    } fetch_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - small synchronous response FIFO with count and clear
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  fetch_rsp_t    push_data,
    input  logic          pop,
    output fetch_rsp_t    head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_rsp_t    slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = slots[rd_ptr];

    // Entry storage, not reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - BRAM instruction memory with valid/ready fetch port
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          OUT_REG   = 0,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic [31:0]              rsp_addr,
    output logic [1:0]               rsp_err,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data
);

    localparam int LAT        = 1 + OUT_REG;
    localparam int FIFO_DEPTH = LAT + 1;
    localparam int IW         = $clog2(DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    (* ram_style = "block" *) logic [31:0] mem [DEPTH];

    logic [31:0]   ram_q;
    logic [31:0]   rel_addr;
    logic [31:0]   word_idx;
    fetch_err_e    req_err;
    logic          accept;
    logic          v1;
    logic [31:0]   addr1;
    fetch_err_e    err1;
    fetch_rsp_t    s1;
    logic          pipe_valid;
    fetch_rsp_t    pipe_rsp;
    logic [1:0]    inflight;
    fetch_rsp_t    fifo_head;
    fetch_rsp_t    cur;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    // Address decode; misalignment wins over out-of-range.
    always_comb begin
        rel_addr = req_addr - BASE_ADDR;
        word_idx = rel_addr >> 2;
        req_err  = ERR_NONE;
        if (req_addr[1:0] != 2'b00) begin
            req_err = ERR_MISALIGN;
        end else if ((req_addr < BASE_ADDR) || (word_idx >= 32'(DEPTH))) begin
            req_err = ERR_RANGE;
        end
    end

    // Credit check: every issued read must have a FIFO slot waiting for it.
    assign req_ready = !rst && !flush &&
                       ((32'(inflight) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // BRAM port: loads ignore rst/flush; reads see pre-write data (read-first).
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
        if (accept) begin
            ram_q <= mem[word_idx[IW-1:0]];
        end
    end

    // Read-stage tag; clearing valid discards reads issued before a flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1 <= 1'b0;
        end else begin
            v1 <= accept;
        end
        if (rst) begin
            addr1 <= '0;
            err1  <= ERR_NONE;
        end else if (accept) begin
            addr1 <= req_addr;
            err1  <= req_err;
        end
    end

    // Errored fetches substitute a NOP for whatever the BRAM returned.
    always_comb begin
        s1.inst = (err1 == ERR_NONE) ? ram_q : NOP_INST;
        s1.addr = addr1;
        s1.err  = err1;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic       v2;
            fetch_rsp_t s2;

            // Optional output register stage, invalidated on flush/rst.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                end
                if (rst) begin
                    s2 <= '0;
                end else if (v1) begin
                    s2 <= s1;
                end
            end

            assign pipe_valid = v2;
            assign pipe_rsp   = s2;
            assign inflight   = {1'b0, v1} + {1'b0, v2};
        end else begin : g_no_out_reg
            assign pipe_valid = v1;
            assign pipe_rsp   = s1;
            assign inflight   = {1'b0, v1};
        end
    endgenerate

    // Results bypass the FIFO only when it is empty and the consumer is ready.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = !rst && !fifo_empty && rsp_ready;
    assign fifo_push  = !rst && pipe_valid && !(fifo_empty && rsp_ready);

    imem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .clr       (rst || flush),
        .push      (fifo_push),
        .push_data (pipe_rsp),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign cur       = fifo_empty ? pipe_rsp : fifo_head;
    assign rsp_valid = !rst && (!fifo_empty || pipe_valid);
    assign rsp_inst  = rsp_valid ? cur.inst : 32'h0;
    assign rsp_addr  = rsp_valid ? cur.addr : 32'h0;
    assign rsp_err   = rsp_valid ? cur.err : 2'b00;

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - directed self-checking bench for imem_fetch_port
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    logic        req_ready0, rsp_valid0, req_ready1, rsp_valid1;
    logic [31:0] rsp_inst0, rsp_addr0, rsp_inst1, rsp_addr1;
    logic [1:0]  rsp_err0, rsp_err1;

    logic [31:0] img [4];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    imem_fetch_port #(.DEPTH(1024), .BASE_ADDR(32'h0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_addr(req_addr), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst0), .rsp_addr(rsp_addr0), .rsp_err(rsp_err0),
        .flush(flush), .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    imem_fetch_port #(.DEPTH(1024), .BASE_ADDR(32'h0), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_addr(req_addr), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst1), .rsp_addr(rsp_addr1), .rsp_err(rsp_err1),
        .flush(flush), .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_sync();
        flush = 1'b1;
        req_valid = 1'b0;
        step();
        flush = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_en = 1'b1;
            load_idx = 10'(k);
            load_data = img[k];
            step();
        end
        load_en = 1'b0;
        req_valid = 1'b1;
        #2;
        checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL reset_req_ready0: got %b, expected 0", req_ready0); end
        checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL reset_req_ready1: got %b, expected 0", req_ready1); end
        checks++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b, expected 00", rsp_valid0, rsp_valid1); end
        checks++; if (rsp_inst0 !== 32'h0 || rsp_addr0 !== 32'h0 || rsp_err0 !== 2'b00) begin
            errors++; $display("FAIL reset_rsp_fields: got inst %h addr %h err %b, expected zeros", rsp_inst0, rsp_addr0, rsp_err0);
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k < 4);
            req_addr = 32'(4 * k);
            #2;
            if (k < 4) begin
                checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d: got %b, expected 1", k, req_ready0); end
            end
            if (k == 0) begin
                checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b, expected 0", rsp_valid0); end
            end else begin
                checks++; if (rsp_valid0 !== 1'b1 || rsp_inst0 !== img[k-1] || rsp_addr0 !== 32'(4 * (k - 1)) || rsp_err0 !== 2'b00) begin
                    errors++; $display("FAIL b2b_rsp c%0d: got v%b inst %h addr %h err %b, expected v1 inst %h addr %h err 00",
                                       k, rsp_valid0, rsp_inst0, rsp_addr0, rsp_err0, img[k-1], 32'(4 * (k - 1)));
                end
            end
            step();
        end
        req_valid = 1'b0;
        #2;
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid: got %b, expected 0", rsp_valid0); end
        step();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic [1:0]  exp_err [4];
        addrs[0] = 32'h2;    exp_err[0] = 2'b01;
        addrs[1] = 32'h1000; exp_err[1] = 2'b10;
        addrs[2] = 32'h1001; exp_err[2] = 2'b01;
        addrs[3] = 32'hFFC;  exp_err[3] = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr = addrs[i];
            step();
            req_valid = 1'b0;
            #2;
            checks++; if (rsp_valid0 !== 1'b1 || rsp_err0 !== exp_err[i] || rsp_addr0 !== addrs[i]) begin
                errors++; $display("FAIL err_rsp %h: got v%b err %b addr %h, expected v1 err %b addr %h",
                                   addrs[i], rsp_valid0, rsp_err0, rsp_addr0, exp_err[i], addrs[i]);
            end
            if (exp_err[i] != 2'b00) begin
                checks++; if (rsp_inst0 !== NOP) begin errors++; $display("FAIL err_nop %h: got %h, expected %h", addrs[i], rsp_inst0, NOP); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int   seen;
        logic acc_now;
        flush_sync();
        seen = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h0;
        for (int c = 0; c < 5; c++) begin
            #2;
            acc_now = req_ready1;
            if (acc_now) seen++;
            if (c >= 2) begin
                checks++; if (rsp_valid1 !== 1'b1 || rsp_addr1 !== 32'h0 || rsp_inst1 !== img[0]) begin
                    errors++; $display("FAIL bp_hold c%0d: got v%b addr %h inst %h, expected v1 addr 0 inst %h", c, rsp_valid1, rsp_addr1, rsp_inst1, img[0]);
                end
            end
            step();
            if (acc_now) req_addr = req_addr + 32'h4;
        end
        req_valid = 1'b0;
        #2;
        checks++; if (seen != 3) begin errors++; $display("FAIL bp_accepts: got %0d, expected 3", seen); end
        checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b, expected 0", req_ready1); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (rsp_valid1 !== 1'b1 || rsp_addr1 !== 32'(4 * i) || rsp_inst1 !== img[i]) begin
                errors++; $display("FAIL bp_drain %0d: got v%b addr %h inst %h, expected v1 addr %h inst %h",
                                   i, rsp_valid1, rsp_addr1, rsp_inst1, 32'(4 * i), img[i]);
            end
            step();
        end
        #2;
        checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b, expected 0", rsp_valid1); end
        step();
    endtask

    task automatic test_flush();
        int n0;
        int n1;
        flush_sync();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        flush = 1'b1;
        req_addr = 32'h8;
        #2;
        checks++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b%b, expected 00", req_ready0, req_ready1);
        end
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
                errors++; $display("FAIL flush_quiet c%0d: got %b%b, expected 00", c, rsp_valid0, rsp_valid1);
            end
            step();
        end
        req_valid = 1'b1;
        req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 4; c++) begin
            #2;
            if (rsp_valid0) begin
                n0++;
                checks++; if (rsp_inst0 !== img[2]) begin errors++; $display("FAIL flush_refetch0: got %h, expected %h", rsp_inst0, img[2]); end
            end
            if (rsp_valid1) begin
                n1++;
                checks++; if (rsp_inst1 !== img[2]) begin errors++; $display("FAIL flush_refetch1: got %h, expected %h", rsp_inst1, img[2]); end
            end
            step();
        end
        checks++; if (n0 != 1 || n1 != 1) begin errors++; $display("FAIL flush_count: got %0d/%0d, expected 1/1", n0, n1); end
    endtask

    task automatic test_load_read_first();
        rsp_ready = 1'b1;
        load_en = 1'b1;
        load_idx = 10'd1;
        load_data = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_addr = 32'h4;
        step();
        load_en = 1'b0;
        #2;
        checks++; if (rsp_valid0 !== 1'b1 || rsp_inst0 !== 32'h00100113) begin
            errors++; $display("FAIL rf_old0: got v%b %h, expected v1 00100113", rsp_valid0, rsp_inst0);
        end
        step();
        req_valid = 1'b0;
        #2;
        checks++; if (rsp_valid0 !== 1'b1 || rsp_inst0 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rf_new0: got v%b %h, expected v1 deadbeef", rsp_valid0, rsp_inst0);
        end
        checks++; if (rsp_valid1 !== 1'b1 || rsp_inst1 !== 32'h00100113) begin
            errors++; $display("FAIL rf_old1: got v%b %h, expected v1 00100113", rsp_valid1, rsp_inst1);
        end
        step();
        #2;
        checks++; if (rsp_valid1 !== 1'b1 || rsp_inst1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rf_new1: got v%b %h, expected v1 deadbeef", rsp_valid1, rsp_inst1);
        end
        step();
        step();
    endtask

    task automatic test_reset_midstream();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h0;
        step();
        req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        step();
        #2;
        checks++; if (rsp_valid0 !== 1'b1 || rsp_addr0 !== 32'h0) begin
            errors++; $display("FAIL mid_buffered: got v%b addr %h, expected v1 addr 0", rsp_valid0, rsp_addr0);
        end
        rst = 1'b1;
        #1;
        checks++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready: got %b%b, expected 00", req_ready0, req_ready1);
        end
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
                errors++; $display("FAIL mid_stale c%0d: got %b%b, expected 00", c, rsp_valid0, rsp_valid1);
            end
            step();
        end
        req_valid = 1'b1;
        req_addr = 32'hC;
        step();
        req_valid = 1'b0;
        #2;
        checks++; if (rsp_valid0 !== 1'b1 || rsp_inst0 !== img[3] || rsp_addr0 !== 32'hC) begin
            errors++; $display("FAIL mid_resume: got v%b inst %h addr %h, expected v1 inst %h addr 0000000c", rsp_valid0, rsp_inst0, rsp_addr0, img[3]);
        end
        step();
        step();
    endtask

    initial begin
        img[0] = 32'h00500093;
        img[1] = 32'h00100113;
        img[2] = 32'h002081B3;
        img[3] = 32'h0000006F;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'h0;
        rsp_ready = 1'b1;
        flush = 1'b0;
        load_en = 1'b0;
        load_idx = 10'd0;
        load_data = 32'h0;
        step();
        test_reset();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_flush();
        test_load_read_first();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
